// File: rtl/img_sram_pkg.sv
// Shared types and encodings for the image SRAM streaming DMA.
package img_sram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] coord_t;
    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic {
        MODE_LOAD = 1'b0,
        MODE_DUMP = 1'b1
    } dma_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LFIN,
        ST_DUMP,
        ST_DFIN
    } dma_state_e;

    typedef struct packed {
        logic we;
        logic se;
    } sram_op_t;

    localparam sram_op_t SRAM_WRITE = '{we: 1'b1, se: 1'b1};
    localparam sram_op_t SRAM_READ  = '{we: 1'b0, se: 1'b0};
    localparam sram_op_t SRAM_HOLD  = '{we: 1'b0, se: 1'b1};

    // Read data travels with its end-of-frame marker so m_last needs no extra counter.
    typedef struct packed {
        logic   last;
        pixel_t data;
    } rd_ent_t;

    function automatic logic at_frame_end(input coord_t row, input coord_t col,
                                          input coord_t rows_m1, input coord_t cols_m1);
        return (row == rows_m1) && (col == cols_m1);
    endfunction

endpackage

// File: rtl/img_sram_rd_fifo.sv
// Two-entry read-data FIFO between the SRAM read port and the DUMP stream.
module img_sram_rd_fifo
    import img_sram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rd_ent_t    push_ent,
    input  logic       pop,
    output logic [1:0] count,
    output rd_ent_t    head
);

    rd_ent_t    mem_q [2];
    rd_ent_t    mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_ent;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/img_sram_dma.sv
// Streaming DMA: raster-order fill (LOAD) and drain (DUMP) of the 256x256x8 image SRAM.
//   state | meaning
//   IDLE  | waiting for start; SRAM held
//   LOAD  | accepting s_* beats, one WRITE per beat
//   LFIN  | last write registered; pulse done
//   DUMP  | issuing READs while FIFO + in-flight has room
//   DFIN  | all reads issued; draining until the last pixel pops
module img_sram_dma
    import img_sram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] rows_m1,
    input  logic [ADDR_W-1:0] cols_m1,
    output logic              busy,
    output logic              done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [ADDR_W-1:0] sram_row,
    output logic [ADDR_W-1:0] sram_col,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_write_en,
    output logic              sram_sense_en,
    input  logic [DATA_W-1:0] sram_dout
);

    dma_state_e state_q, state_d;
    coord_t     rows_q, rows_d;
    coord_t     cols_q, cols_d;
    coord_t     row_q, row_d;
    coord_t     col_q, col_d;
    sram_op_t   op_q, op_d;
    coord_t     addr_row_q, addr_row_d;
    coord_t     addr_col_q, addr_col_d;
    pixel_t     din_q, din_d;
    logic       done_q, done_d;
    logic       inflight_q, inflight_d;
    logic       inflight_last_q, inflight_last_d;

    coord_t     row_adv, col_adv;
    logic       frame_end;
    logic       pop;
    logic [1:0] fifo_count;
    rd_ent_t    fifo_head;
    rd_ent_t    push_ent;
    logic [2:0] occ;

    assign frame_end = at_frame_end(row_q, col_q, rows_q, cols_q);

    // Raster advance; row may wrap on the final pixel of a 256-row frame, which is harmless
    // because frame_end has already moved the state on.
    always_comb begin
        if (col_q == cols_q) begin
            col_adv = '0;
            row_adv = row_q + coord_t'(1);
        end else begin
            col_adv = col_q + coord_t'(1);
            row_adv = row_q;
        end
    end

    assign pop      = m_valid && m_ready;
    assign occ      = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign push_ent = '{last: inflight_last_q, data: sram_dout};

    always_comb begin
        state_d         = state_q;
        rows_d          = rows_q;
        cols_d          = cols_q;
        row_d           = row_q;
        col_d           = col_q;
        op_d            = SRAM_HOLD;
        addr_row_d      = addr_row_q;
        addr_col_d      = addr_col_q;
        din_d           = din_q;
        done_d          = 1'b0;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rows_d  = rows_m1;
                    cols_d  = cols_m1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = (dma_mode_e'(mode) == MODE_DUMP) ? ST_DUMP : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (s_valid && s_ready) begin
                    op_d       = SRAM_WRITE;
                    addr_row_d = row_q;
                    addr_col_d = col_q;
                    din_d      = s_data;
                    row_d      = row_adv;
                    col_d      = col_adv;
                    if (frame_end) begin
                        state_d = ST_LFIN;
                    end
                end
            end
            ST_LFIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_DUMP: begin
                if (occ < 3'd2) begin
                    op_d            = SRAM_READ;
                    addr_row_d      = row_q;
                    addr_col_d      = col_q;
                    inflight_d      = 1'b1;
                    inflight_last_d = frame_end;
                    row_d           = row_adv;
                    col_d           = col_adv;
                    if (frame_end) begin
                        state_d = ST_DFIN;
                    end
                end
            end
            ST_DFIN: begin
                if (pop && fifo_head.last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rows_q          <= '0;
            cols_q          <= '0;
            row_q           <= '0;
            col_q           <= '0;
            op_q            <= SRAM_HOLD;
            addr_row_q      <= '0;
            addr_col_q      <= '0;
            din_q           <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rows_q          <= rows_d;
            cols_q          <= cols_d;
            row_q           <= row_d;
            col_q           <= col_d;
            op_q            <= op_d;
            addr_row_q      <= addr_row_d;
            addr_col_q      <= addr_col_d;
            din_q           <= din_d;
            done_q          <= done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // sram_dout is captured only on the edge after a READ was registered.
    img_sram_rd_fifo u_rd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_ent (push_ent),
        .pop      (pop),
        .count    (fifo_count),
        .head     (fifo_head)
    );

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign s_ready       = (state_q == ST_LOAD);
    assign m_valid       = (fifo_count != 2'd0);
    assign m_data        = fifo_head.data;
    assign m_last        = m_valid && fifo_head.last;
    assign sram_row      = addr_row_q;
    assign sram_col      = addr_col_q;
    assign sram_din      = din_q;
    assign sram_write_en = op_q.we;
    assign sram_sense_en = op_q.se;

endmodule

// File: tb/tb_img_sram_dma.sv
// Directed bench for img_sram_dma with a behavioural 256x256x8 SRAM acting on the clk-low phase.
module tb_img_sram_dma;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, mode;
    logic [7:0] rows_m1, cols_m1;
    logic       busy, done;
    logic       s_valid, s_ready;
    logic [7:0] s_data;
    logic       m_valid, m_ready, m_last;
    logic [7:0] m_data;
    logic [7:0] sram_row, sram_col, sram_din;
    logic       sram_write_en, sram_sense_en;
    logic [7:0] dout_drv;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    img_sram_dma dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .rows_m1       (rows_m1),
        .cols_m1       (cols_m1),
        .busy          (busy),
        .done          (done),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .sram_row      (sram_row),
        .sram_col      (sram_col),
        .sram_din      (sram_din),
        .sram_write_en (sram_write_en),
        .sram_sense_en (sram_sense_en),
        .sram_dout     (dout_drv)
    );

    // SRAM model: preloaded with row^col, acts on the low phase; drives junk when not reading.
    logic [7:0] mem [256][256];
    logic       mem_init = 1'b0;
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int r = 0; r < 256; r++)
                for (int c = 0; c < 256; c++)
                    mem[r][c] = 8'(r ^ c);
            mem_init = 1'b1;
        end
        if (sram_write_en && sram_sense_en)
            mem[sram_row][sram_col] = sram_din;
        if (!sram_write_en && !sram_sense_en)
            dout_drv = mem[sram_row][sram_col];
        else
            dout_drv = 8'hEE;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int pat, input int k, input int cols);
        if (pat == 0) return 8'(8'h10 + k);
        if (pat == 1) return 8'((k / (cols + 1)) ^ (k % (cols + 1)));
        return 8'(8'hA0 + k);
    endfunction

    task automatic run_load(input int rows, input int cols, input int pat, input int gap);
        int n = (rows + 1) * (cols + 1);
        int k = 0;
        int cyc = 0;
        int dones = 0;
        start = 1'b1; mode = 1'b0;
        rows_m1 = 8'(rows); cols_m1 = 8'(cols);
        tick;
        start = 1'b0;
        check_eq("load_busy", {31'b0, busy}, 1);
        check_eq("load_s_ready", {31'b0, s_ready}, 1);
        while (k < n && cyc < 2 * n + 10) begin
            s_valid = !(gap != 0 && (cyc % 2) == 1);
            s_data  = pix(pat, k, cols);
            tick;
            cyc++;
            if (s_valid) begin
                check_eq("load_write_op", {30'b0, sram_write_en, sram_sense_en}, 2'b11);
                check_eq("load_addr", {16'b0, sram_row, sram_col},
                         {16'b0, 8'(k / (cols + 1)), 8'(k % (cols + 1))});
                check_eq("load_din", {24'b0, sram_din}, {24'b0, pix(pat, k, cols)});
                k++;
            end else begin
                check_eq("load_gap_hold", {30'b0, sram_write_en, sram_sense_en}, 2'b01);
            end
            if (done) dones++;
        end
        s_valid = 1'b0;
        check_eq("load_beats", k, n);
        check_eq("load_early_done", dones, 0);
        check_eq("load_lfin_s_ready", {31'b0, s_ready}, 0);
        tick;
        check_eq("load_done", {31'b0, done}, 1);
        check_eq("load_idle", {31'b0, busy}, 0);
        check_eq("load_fin_hold", {30'b0, sram_write_en, sram_sense_en}, 2'b01);
        tick;
        check_eq("load_done_pulse", {31'b0, done}, 0);
    endtask

    task automatic run_dump(input int rows, input int cols, input int pat, input int toggle);
        int n = (rows + 1) * (cols + 1);
        int k = 0;
        int cyc = 0;
        int reads = 0;
        int dones = 0;
        int holds = 0;
        int first_read = -1;
        int last_read = -1;
        int first_valid = -1;
        int done_cyc = -1;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        start = 1'b1; mode = 1'b1;
        rows_m1 = 8'(rows); cols_m1 = 8'(cols);
        m_ready = 1'b1;
        tick;
        start = 1'b0;
        while (dones == 0 && cyc < n * 3 + 20) begin
            m_ready = (toggle != 0) ? ((cyc % 2) == 0) : 1'b1;
            if (prev_stall)
                check_eq("dump_stable", {23'b0, m_valid, m_data}, {23'b0, 1'b1, prev_data});
            if (m_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (m_ready) begin
                    check_eq("dump_data", {24'b0, m_data}, {24'b0, pix(pat, k, cols)});
                    check_eq("dump_last", {31'b0, m_last}, {31'b0, k == n - 1});
                    k++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            tick;
            cyc++;
            check_eq("dump_no_write", {31'b0, sram_write_en}, 0);
            if (!sram_write_en && !sram_sense_en) begin
                check_eq("dump_read_addr", {16'b0, sram_row, sram_col},
                         {16'b0, 8'(reads / (cols + 1)), 8'(reads % (cols + 1))});
                if (first_read < 0) first_read = cyc;
                last_read = cyc;
                reads++;
            end else if (busy) begin
                holds++;
            end
            check_eq("dump_occupancy", {31'b0, (reads - k) <= 2}, 1);
            if (done) begin
                dones++;
                done_cyc = cyc;
                check_eq("dump_done_idle", {31'b0, busy}, 0);
            end
        end
        m_ready = 1'b0;
        check_eq("dump_pixels", k, n);
        check_eq("dump_reads", reads, n);
        check_eq("dump_done_count", dones, 1);
        if (toggle != 0) begin
            check_eq("dump_stall_holds", {31'b0, holds > 0}, 1);
        end else begin
            check_eq("dump_first_read", first_read, 1);
            check_eq("dump_last_read", last_read, n);
            check_eq("dump_first_valid", first_valid, 2);
            check_eq("dump_done_cyc", done_cyc, n + 2);
        end
        tick;
        check_eq("dump_done_pulse", {31'b0, done}, 0);
        check_eq("dump_drained", {31'b0, m_valid}, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0;
        rows_m1 = 8'd0; cols_m1 = 8'd0;
        s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_op", {30'b0, sram_write_en, sram_sense_en}, 2'b01);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_done", {31'b0, done}, 0);
        check_eq("rst_s_ready", {31'b0, s_ready}, 0);
        check_eq("rst_m_valid", {29'b0, m_valid, m_last, 1'b0}, 0);
        check_eq("rst_addr_din", {8'b0, sram_row, sram_col, sram_din}, 0);
        rst_n = 1'b1;
        tick;
        check_eq("idle_busy", {31'b0, busy}, 0);

        // 2x3 frame, gaps every other cycle, then drain it at full rate and with a stalling sink.
        run_load(1, 2, 0, 1);
        run_dump(1, 2, 0, 0);
        run_dump(1, 2, 0, 1);

        // Full-width/full-height edges on LOAD, then the complete 256x256 drain.
        run_load(255, 1, 1, 0);
        run_load(1, 255, 1, 0);
        run_dump(255, 255, 1, 0);

        // start during DUMP is ignored; reset mid-frame clears everything at once.
        start = 1'b1; mode = 1'b1; rows_m1 = 8'd1; cols_m1 = 8'd2; m_ready = 1'b1;
        tick;
        start = 1'b0;
        tick;
        check_eq("ign_read0", {14'b0, sram_write_en, sram_sense_en, sram_row, sram_col}, {14'b0, 2'b00, 8'd0, 8'd0});
        start = 1'b1; mode = 1'b0; rows_m1 = 8'd0; cols_m1 = 8'd0;
        tick;
        start = 1'b0;
        check_eq("ign_busy", {31'b0, busy}, 1);
        check_eq("ign_s_ready", {31'b0, s_ready}, 0);
        check_eq("ign_read1", {14'b0, sram_write_en, sram_sense_en, sram_row, sram_col}, {14'b0, 2'b00, 8'd0, 8'd1});
        tick;
        check_eq("ign_read2", {14'b0, sram_write_en, sram_sense_en, sram_row, sram_col}, {14'b0, 2'b00, 8'd0, 8'd2});
        check_eq("ign_m_valid", {31'b0, m_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_op", {30'b0, sram_write_en, sram_sense_en}, 2'b01);
        check_eq("rstmid_busy_done", {30'b0, busy, done}, 0);
        check_eq("rstmid_streams", {29'b0, s_ready, m_valid, m_last}, 0);
        check_eq("rstmid_addr_din", {8'b0, sram_row, sram_col, sram_din}, 0);
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick;
        run_load(1, 2, 2, 0);
        run_dump(1, 2, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/img_sram_dma.md
Name: img_sram_dma

Overview:
Streaming DMA engine that sits directly upstream and downstream of the 256x256x8 image SRAM wrapper. It fills the SRAM from a valid/ready pixel stream in raster order (LOAD) and drains it to a valid/ready stream (DUMP). It generates the SRAM write/read/hold encodings and captures read data. The convolution core and the host-side loader connect through its streams.

Parameters:
ADDR_W, 8, row/col coordinate width
DATA_W, 8, pixel width

Ports:
clk  in  1  system clock; also drives the SRAM clk
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle command strobe, accepted only in IDLE
mode  in  1  0=LOAD, 1=DUMP; sampled with start
rows_m1  in  ADDR_W  frame height minus 1; latched at start
cols_m1  in  ADDR_W  frame width minus 1; latched at start
busy  out  1  high while not in IDLE
done  out  1  one-cycle completion pulse
s_valid/s_ready/s_data  in/out/in  1/1/DATA_W  LOAD pixel stream
m_valid/m_ready/m_data/m_last  out/in/out/out  1/1/DATA_W/1  DUMP pixel stream; m_last marks the final pixel
sram_row, sram_col  out  ADDR_W  SRAM address
sram_din  out  DATA_W  SRAM write data
sram_write_en, sram_sense_en  out  1  SRAM op encoding
sram_dout  in  DATA_W  SRAM read data; tri-stated except when sampled

Behaviour:
- SRAM encodings, all driven from registers: WRITE = we=1,se=1; READ = we=0,se=0; HOLD = we=0,se=1.
- The SRAM acts on the clk-low phase after the edge that registers a command.
- Read data is sampled on the next rising edge only. sram_dout is ignored at all other times.
- Reset values: state IDLE, we=0, se=1 (HOLD), row/col/din=0, busy=0, done=0, s_ready=0, m_valid=0, m_last=0, FIFO empty, in-flight=0.
- States: IDLE, LOAD, LFIN, DUMP, DFIN.
- IDLE:
  - start=1: latch rows_m1 and cols_m1, clear the cursor to (0,0), go to LOAD or DUMP.
  - start in any other state is ignored.
- LOAD:
  - s_ready=1.
  - Each s_valid&s_ready edge registers WRITE with the cursor address and din=s_data, then advances the cursor.
  - Edges with no beat register HOLD.
  - The beat at (rows_m1, cols_m1) moves the state to LFIN; s_ready is 0 from then on.
- LFIN: register HOLD, pulse done, go to IDLE.
- Cursor rules:
  - col increments; at cols_m1 it wraps to 0 and row increments.
  - Full 256x256 (both values 255) needs no wider counters. A separate last flag ends the frame; 8-bit wrap alone does not.
- DUMP read issue:
  - Issue a READ at the cursor and advance when fifo_count + inflight − pop < 2. pop = m_valid&m_ready on the same edge.
  - Otherwise register HOLD.
  - inflight is set on the issue edge. On the following edge sram_dout is pushed into the 2-entry FIFO.
  - Sustained rate is 1 pixel/clk with m_ready=1. First m_valid appears 2 edges after entering DUMP.
  - The FIFO can never overflow.
- After the last address is issued, go to DFIN and stop issuing.
- m_valid = FIFO non-empty; m_data = FIFO head.
- m_last=1 with the frame's final pixel.
- DFIN: when the final pixel pops, pulse done on the next edge and go to IDLE.
- Stream rules:
  - m_data and m_valid hold stable while m_valid&!m_ready.
  - s_ready never depends combinationally on s_valid.
- Async reset mid-operation returns every output to its reset value immediately, ending any SRAM op as HOLD. Partial SRAM contents are undefined.

Decomposition:
- Package img_sram_pkg:
  - ADDR_W, DATA_W
  - pixel_t, coord_t
  - dma_mode_e: MODE_LOAD=0, MODE_DUMP=1
  - dma_state_e
  - sram_op encoding constants: WRITE, READ, HOLD
- Sub-module img_sram_rd_fifo: 2-entry FIFO with push, pop, count, head.

Test Plan:
- Reset -> we=0, se=1, busy=0, s_ready=0, m_valid=0, done=0.
- LOAD with rows_m1=1, cols_m1=2, data 0x10..0x15, s_valid gaps every other cycle -> 6 WRITE cycles at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); HOLD in the gaps; done one cycle after the last write.
- DUMP of the same frame, m_ready=1 -> READ on 6 consecutive cycles; m_data 0x10..0x15 on consecutive cycles starting 2 edges after start; m_last on 0x15; done next edge.
- DUMP with m_ready toggling 1010... -> data order preserved, no drops or duplicates, in-flight+FIFO never >2, HOLD issued while stalled.
- Full 256x256 LOAD then DUMP, pixel = row^col -> all 65536 match; row/col wrap correctly; exactly one done per command.
- start pulsed during DUMP, then rst_n asserted mid-frame -> start ignored; on reset all outputs return to reset values immediately; a new LOAD after reset works.
